// File: rtl/debounce_sync.sv
`timescale 1ns/1ps
// Synchronise a raw asynchronous level into clk, then accept a change only after it
// has been seen for STABLE_CYCLES consecutive cycles; emits registered rise/fall strobes.
module debounce_sync #(
  parameter int   SYNC_STAGES   = 2,
  parameter int   STABLE_CYCLES = 4,
  parameter logic RESET_LEVEL   = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic q,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam int            CW       = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_CHECK  = 1'b1
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   q_q, q_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   busy_q, busy_d;
  logic                   s;

  // Stage 0 is the metastability catcher; only the last stage feeds logic.
  assign sync_d = {sync_q[SYNC_STAGES-2:0], din};
  assign s      = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= {SYNC_STAGES{RESET_LEVEL}};
      state_q <= ST_STABLE;
      cnt_q   <= '0;
      q_q     <= RESET_LEVEL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    unique case (state_q)
      ST_STABLE: begin
        if (s != q_q) begin
          // Single-cycle qualification needs no CHECK visit.
          if (STABLE_CYCLES == 1) begin
            q_d = s;
          end else begin
            state_d = ST_CHECK;
            cnt_d   = CW'(1);
          end
        end else begin
          cnt_d = '0;
        end
      end
      ST_CHECK: begin
        if (s == q_q) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          q_d     = s;
          cnt_d   = '0;
          state_d = ST_STABLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    endcase
    rise_d = q_d & ~q_q;
    fall_d = ~q_d & q_q;
    busy_d = (state_d == ST_CHECK);
  end

  assign q    = q_q;
  assign rise = rise_q;
  assign fall = fall_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_debounce_sync.sv
`timescale 1ns/1ps
// Bench for debounce_sync: two configurations checked every cycle against a
// sliding-window model, plus directed scenarios with literal expectations.
module tb_debounce_sync;

  localparam int   SS_A = 2;
  localparam int   SC_A = 4;
  localparam logic RL_A = 1'b0;
  localparam int   SS_B = 3;
  localparam int   SC_B = 1;
  localparam logic RL_B = 1'b1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic din_a = 1'b1;
  logic din_b = 1'b1;
  logic q_a, rise_a, fall_a, busy_a;
  logic q_b, rise_b, fall_b, busy_b;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  debounce_sync dut_a (
    .clk(clk), .reset(reset), .din(din_a),
    .q(q_a), .rise(rise_a), .fall(fall_a), .busy(busy_a)
  );

  debounce_sync #(.SYNC_STAGES(SS_B), .STABLE_CYCLES(SC_B), .RESET_LEVEL(RL_B)) dut_b (
    .clk(clk), .reset(reset), .din(din_b),
    .q(q_b), .rise(rise_b), .fall(fall_b), .busy(busy_b)
  );

  task automatic chk(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: delay line of din samples, then a log of every s value seen since reset.
  // q flips when the last STABLE_CYCLES logged values all differ from q.
  bit sh   [2][4];
  bit slog [2][512];
  int sn   [2];
  bit mq [2], mr [2], mf [2], mb [2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      bit rl = (i == 0) ? RL_A : RL_B;
      for (int j = 0; j < 4; j++) sh[i][j] = rl;
      sn[i] = 0;
      mq[i] = rl;
      mr[i] = 1'b0;
      mf[i] = 1'b0;
      mb[i] = 1'b0;
    end
  endtask

  task automatic model_step(input int i, input bit d);
    int ss = (i == 0) ? SS_A : SS_B;
    int sc = (i == 0) ? SC_A : SC_B;
    bit s, chg, stop;
    int run;
    s = sh[i][ss-1];
    for (int j = 3; j > 0; j--) sh[i][j] = sh[i][j-1];
    sh[i][0] = d;
    slog[i][sn[i] % 512] = s;
    sn[i]++;
    chg = (sn[i] >= sc);
    for (int k = 0; k < sc && k < sn[i]; k++)
      if (slog[i][(sn[i] - 1 - k) % 512] == mq[i]) chg = 1'b0;
    mr[i] = chg && !mq[i];
    mf[i] = chg && mq[i];
    if (chg) mq[i] = !mq[i];
    run = 0;
    stop = 1'b0;
    for (int k = 0; k < sn[i] && k < sc; k++) begin
      if (slog[i][(sn[i] - 1 - k) % 512] == mq[i]) stop = 1'b1;
      if (!stop) run++;
    end
    mb[i] = (run > 0);
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) model_reset();
    else begin
      model_step(0, din_a);
      model_step(1, din_b);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_q_a", q_a, mq[0]);
      chk("cyc_rise_a", rise_a, mr[0]);
      chk("cyc_fall_a", fall_a, mf[0]);
      chk("cyc_busy_a", busy_a, mb[0]);
      chk("cyc_q_b", q_b, mq[1]);
      chk("cyc_rise_b", rise_b, mr[1]);
      chk("cyc_fall_b", fall_b, mf[1]);
      chk("cyc_busy_b", busy_b, mb[1]);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int n, nb, ri, fi, hold_a, hold_b;
    bit found, saw, saw_busy;
    model_reset();
    reset = 1'b1;
    din_a = 1'b1;
    din_b = 1'b1;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_q_a", q_a, 1'b0);
    chk("rst_rise_a", rise_a, 1'b0);
    chk("rst_fall_a", fall_a, 1'b0);
    chk("rst_busy_a", busy_a, 1'b0);
    chk("rst_q_b", q_b, 1'b1);
    @(negedge clk);
    reset = 1'b0;

    // Release with din already high: rise on the 6th edge after release.
    n = 0; found = 0;
    for (int e = 1; e <= 20 && !found; e++) begin
      @(negedge clk);
      if (rise_a) begin found = 1; n = e; end
    end
    chk_int("s1_rise_edge", n, 6);
    chk("s1_q", q_a, 1'b1);

    // Falling change: busy for 3 cycles, then fall.
    din_a = 1'b0;
    n = 0; nb = 0; found = 0;
    for (int e = 1; e <= 20 && !found; e++) begin
      @(negedge clk);
      if (busy_a) nb++;
      if (fall_a) begin found = 1; n = e; end
    end
    chk_int("s2f_fall_edge", n, 6);
    chk_int("s2f_busy_cycles", nb, 3);
    @(negedge clk);
    chk("s2f_fall_width", fall_a, 1'b0);

    // Rising change from 0: busy 3 cycles, single rise, no fall.
    din_a = 1'b1;
    n = 0; nb = 0; found = 0; saw = 0;
    for (int e = 1; e <= 20 && !found; e++) begin
      @(negedge clk);
      if (busy_a) nb++;
      if (fall_a) saw = 1;
      if (rise_a) begin found = 1; n = e; end
    end
    chk_int("s2r_rise_edge", n, 6);
    chk_int("s2r_busy_cycles", nb, 3);
    @(negedge clk);
    chk("s2r_rise_width", rise_a, 1'b0);
    chk("s2r_no_fall", saw, 1'b0);

    din_a = 1'b0;
    repeat (8) @(negedge clk);
    chk("s3_pre_q", q_a, 1'b0);

    // Two-cycle glitch: busy shows, no q change, no pulse.
    din_a = 1'b1;
    repeat (2) @(negedge clk);
    din_a = 1'b0;
    saw = 0; saw_busy = 0;
    repeat (10) begin
      @(negedge clk);
      if (rise_a || fall_a) saw = 1;
      if (busy_a) saw_busy = 1;
    end
    chk("s3_q", q_a, 1'b0);
    chk("s3_no_pulse", saw, 1'b0);
    chk("s3_busy_seen", saw_busy, 1'b1);

    // Exactly four cycles high then low: rise, then fall four cycles later.
    din_a = 1'b1;
    repeat (4) @(negedge clk);
    din_a = 1'b0;
    ri = -100; fi = 100;
    for (int e = 1; e <= 16; e++) begin
      @(negedge clk);
      if (rise_a) ri = e;
      if (fall_a) fi = e;
    end
    chk_int("s4_gap", fi - ri, 4);
    chk("s4_q", q_a, 1'b0);

    // Reset mid-CHECK with count at 2.
    din_a = 1'b1;
    found = 0;
    for (int e = 1; e <= 10 && !found; e++) begin
      @(negedge clk);
      if (busy_a) found = 1;
    end
    chk("s5_busy_seen", found, 1'b1);
    @(negedge clk);
    chk("s5_busy_pre", busy_a, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("s5_q", q_a, 1'b0);
    chk("s5_busy", busy_a, 1'b0);
    chk("s5_rise", rise_a, 1'b0);
    chk("s5_fall", fall_a, 1'b0);
    chk("s5_q_b", q_b, 1'b1);
    din_a = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    saw = 0; saw_busy = 0;
    repeat (12) begin
      @(negedge clk);
      if (rise_a || fall_a) saw = 1;
      if (busy_a) saw_busy = 1;
    end
    chk("s5_no_pulse", saw, 1'b0);
    chk("s5_no_busy", saw_busy, 1'b0);
    chk("s5_q_after", q_a, 1'b0);

    // Config B (3 stages, 1 cycle): fall 4 edges after the drive, never busy.
    din_b = 1'b0;
    n = 0; found = 0; saw_busy = 0;
    for (int e = 1; e <= 12 && !found; e++) begin
      @(negedge clk);
      if (busy_b) saw_busy = 1;
      if (fall_b) begin found = 1; n = e; end
    end
    chk_int("s6_fall_edge", n, 4);
    chk("s6_q", q_b, 1'b0);
    chk("s6_no_busy", saw_busy, 1'b0);

    // Random run-length stimulus on both instances, one async reset midway.
    hold_a = 1; hold_b = 1;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (--hold_a == 0) begin
        din_a = ~din_a;
        hold_a = $urandom_range(1, 7);
      end
      if (--hold_b == 0) begin
        din_b = ~din_b;
        hold_b = $urandom_range(1, 3);
      end
      if (c == 1000) begin
        #3 reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end
    end

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/debounce_sync.md
# debounce_sync

- Input-conditioning stage that sits directly upstream of the team's D flip-flop stages.
- Takes a raw asynchronous level (push-button, switch, external strobe) and synchronises it into the `clk` domain.
- Rejects pulses shorter than a programmable number of cycles.
- Delivers a clean registered level plus single-cycle rise/fall pulses, suitable to drive a downstream flop's `d` input directly.

## Interface

Parameters:
- SYNC_STAGES, default 2: number of synchroniser flops; legal range 2..4.
- STABLE_CYCLES, default 4: consecutive cycles the synchronised input must differ from `q` before `q` changes; legal range 1..255.
- RESET_LEVEL, default 1'b0: value loaded into synchroniser flops and `q` on reset.

Ports:
- clk  input  1  single clock, all state updates on posedge.
- reset  input  1  asynchronous, active-high; one clock; reset is asynchronous and active-high.
- din  input  1  raw asynchronous input level.
- q  output  1  debounced, registered level.
- rise  output  1  one-cycle pulse when `q` goes 0->1.
- fall  output  1  one-cycle pulse when `q` goes 1->0.
- busy  output  1  high while a candidate change is being qualified (state CHECK).

## Operation

Reset (asserted, asynchronously):
- All synchroniser flops = RESET_LEVEL.
- q = RESET_LEVEL.
- rise = 0, fall = 0, busy = 0.
- Counter = 0, state = STABLE.

Synchroniser:
- `din` shifts through SYNC_STAGES flops.
- `s` is the last stage. Only `s` is used by the logic.

Counter and state machine:
- Counter `cnt` has width $clog2(STABLE_CYCLES+1) and never exceeds STABLE_CYCLES.
- STABLE:
  - s == q: hold; cnt = 0.
  - s != q: go to CHECK; cnt = 1.
  - If STABLE_CYCLES == 1: update `q` on this same edge instead and stay in STABLE.
- CHECK:
  - s == q: glitch rejected; return to STABLE; cnt = 0; no pulse.
  - s != q and cnt+1 < STABLE_CYCLES: cnt = cnt+1.
  - s != q and cnt+1 == STABLE_CYCLES: q = s; cnt = 0; go to STABLE; assert rise (if s = 1) or fall (if s = 0).
- `busy` = (state == CHECK), registered.

Output rules:
- `rise` and `fall` are registered, high for exactly one cycle, never high simultaneously, and never asserted on reset entry or exit.
- `q` changes only on the cycle its rise/fall pulse is high.

## Timing

Latency:
- Let `din` first be sampled at the new level on edge k and stay stable.
- `s` changes after edge k+SYNC_STAGES-1.
- `q`, rise/fall and busy-deassert all update after edge k+SYNC_STAGES-1+STABLE_CYCLES. With defaults this is edge k+5.
- `busy` rises one edge after `s` changes, and stays high for STABLE_CYCLES-1 cycles.

Boundary conditions:
- Glitch rejection: any `s` pulse shorter than STABLE_CYCLES cycles produces no `q` change and no pulse. A pulse of exactly STABLE_CYCLES cycles is accepted.
- Toggle during CHECK back to `q` then away again: the count restarts from 1. Counts are never accumulated across interruptions.
- Reset asserted mid-CHECK: the count is abandoned immediately, all outputs return to reset values, and no pulse is emitted.
- Reset release while `din` != RESET_LEVEL: a normal debounce follows, and `q` changes after the full latency.
- Back-to-back accepted changes: the minimum spacing between rise and fall is STABLE_CYCLES cycles.

## Test plan

1. Reset with din = 1 held, then release (defaults) -> q = 0, rise = fall = busy = 0 during reset. After release, q = 1 and rise = 1 for one cycle, at 5 edges after the first post-reset sampling edge.
2. din 0->1 held, defaults -> busy high for 3 cycles, then q = 1 with rise pulse of width 1 cycle. fall stays 0.
3. din glitch high for 2 cycles with STABLE_CYCLES = 4 -> busy pulses; q stays 0; rise and fall stay 0.
4. din high for exactly 4 synchronised cycles, then low for 4 -> rise pulse, then fall pulse 4 cycles later; q returns to 0.
5. Reset asserted asynchronously (mid-cycle) while busy = 1 with count at 2 -> q, busy and pulses go to 0 immediately, with no pulse after release if din = 0.
6. STABLE_CYCLES = 1, SYNC_STAGES = 3, din 1->0 from q = 1 -> q = 0 and fall = 1 three edges after sampling; busy never asserts.
